// File: rtl/ts_pkg.sv
// ----------------------------------------------------------------------
// ts_pkg: shared constants and sync-state type for the TS packet packer
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package ts_pkg;

   localparam logic [7:0] TS_SYNC      = 8'h47;
   localparam int         TS_PKT_BYTES = 188;
   localparam int         TS_PKT_WORDS = 47;
   localparam int         TS_TAG_BIT   = 32;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } sync_state_t;

endpackage

`default_nettype wire

// File: rtl/ts_pkt_ram.sv
// ----------------------------------------------------------------------
// ts_pkt_ram: two-bank packet store, one write port, registered read port
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module ts_pkt_ram
   import ts_pkg::*;
(
   input  logic        clk,
   input  logic        wr_en,
   input  logic [6:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rd_en,
   input  logic [6:0]  rd_addr,
   output logic [31:0] rd_data
);

   localparam int DEPTH = 2 * TS_PKT_WORDS;

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

`default_nettype wire

// File: rtl/ts_pkt_packer.sv
// ----------------------------------------------------------------------
// ts_pkt_packer: TS sync tracker, 32-bit packer and tagged burst reader
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module ts_pkt_packer
   import ts_pkg::*;
#(
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_din,
   input  logic        byte_din_en,
   input  logic [7:0]  chan_id,
   output logic [32:0] ts_dout,
   output logic        ts_dout_en,
   output logic        sync_lock,
   output logic [15:0] drop_cnt
);

   localparam logic [7:0] LAST_BYTE   = 8'(TS_PKT_BYTES - 1);
   localparam logic [5:0] LAST_WORD   = 6'(TS_PKT_WORDS - 1);
   localparam logic [6:0] BANK1_BASE  = 7'(TS_PKT_WORDS);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

   sync_state_t state;
   logic [7:0]  bcnt, good, bad;
   logic        keep;
   logic [23:0] acc;
   logic        wr_ptr, rd_ptr;
   logic [1:0]  full, full_nxt;
   logic [7:0]  bank_chan [2];
   logic        rd_busy;
   logic [5:0]  rd_word;

   logic        is_sync, at_start, sync_ok, start_pkt, drop_now;
   logic        keep_byte, pkt_done, rd_start, rd_last;
   logic        wr_en, rd_en;
   logic [6:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic [32:0] tag_word;

   always_comb begin
      is_sync   = (byte_din == TS_SYNC);
      at_start  = byte_din_en && (bcnt == 8'd0);
      sync_ok   = is_sync && ((state == LOCKED) ||
                              ((state == VERIFY) && (good == LOCK_LAST)));
      start_pkt = 1'b0;
      drop_now  = 1'b0;
      // A good sync into a still-full bank is dropped, as is any bad sync while locked.
      if (at_start && sync_ok) begin
         start_pkt = !full[wr_ptr];
         drop_now  = full[wr_ptr];
      end else if (at_start && (state == LOCKED)) begin
         drop_now  = 1'b1;
      end

      keep_byte = byte_din_en && (start_pkt || keep);
      wr_en     = keep_byte && (bcnt[1:0] == 2'b11);
      wr_addr   = (wr_ptr ? BANK1_BASE : 7'd0) + {1'b0, bcnt[7:2]};
      wr_data   = {acc, byte_din};
      pkt_done  = keep_byte && (bcnt == LAST_BYTE);

      rd_start  = !rd_busy && full[rd_ptr];
      rd_last   = rd_busy && (rd_word == LAST_WORD);
      rd_en     = rd_start || (rd_busy && !rd_last);
      rd_addr   = (rd_ptr ? BANK1_BASE : 7'd0) +
                  {1'b0, (rd_busy ? rd_word + 6'd1 : 6'd0)};

      full_nxt = full;
      if (rd_last)
         full_nxt[rd_ptr] = 1'b0;
      if (pkt_done)
         full_nxt[wr_ptr] = 1'b1;

      tag_word             = '0;
      tag_word[TS_TAG_BIT] = 1'b1;
      tag_word[7:0]        = bank_chan[rd_ptr];
   end

   assign sync_lock = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         bcnt     <= 8'd0;
         good     <= 8'd0;
         bad      <= 8'd0;
         keep     <= 1'b0;
         wr_ptr   <= 1'b0;
         full     <= 2'b00;
         drop_cnt <= 16'd0;
      end else begin
         full <= full_nxt;
         if (drop_now && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
         if (start_pkt)
            keep <= 1'b1;
         if (pkt_done) begin
            keep   <= 1'b0;
            wr_ptr <= ~wr_ptr;
         end
         if (byte_din_en) begin
            case (state)
               HUNT: begin
                  if (is_sync) begin
                     bcnt  <= 8'd1;
                     good  <= 8'd1;
                     state <= VERIFY;
                  end
               end
               VERIFY: begin
                  bcnt <= (bcnt == LAST_BYTE) ? 8'd0 : bcnt + 8'd1;
                  if (bcnt == 8'd0) begin
                     if (!is_sync) begin
                        state <= HUNT;
                        bcnt  <= 8'd0;
                     end else if (good == LOCK_LAST) begin
                        state <= LOCKED;
                        bad   <= 8'd0;
                     end else begin
                        good <= good + 8'd1;
                     end
                  end
               end
               LOCKED: begin
                  bcnt <= (bcnt == LAST_BYTE) ? 8'd0 : bcnt + 8'd1;
                  if (bcnt == 8'd0) begin
                     if (is_sync) begin
                        bad <= 8'd0;
                     end else if (bad == UNLOCK_LAST) begin
                        state <= HUNT;
                        bad   <= 8'd0;
                        bcnt  <= 8'd0;
                        keep  <= 1'b0;
                     end else begin
                        bad <= bad + 8'd1;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   // Big-endian packing: the three most recent bytes wait here for the fourth.
   always_ff @(posedge clk) begin
      if (keep_byte)
         acc <= {acc[15:0], byte_din};
      if (start_pkt)
         bank_chan[wr_ptr] <= chan_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_busy    <= 1'b0;
         rd_word    <= 6'd0;
         rd_ptr     <= 1'b0;
         ts_dout    <= 33'd0;
         ts_dout_en <= 1'b0;
      end else begin
         ts_dout_en <= rd_start || rd_busy;
         if (rd_start) begin
            ts_dout <= tag_word;
            rd_busy <= 1'b1;
            rd_word <= 6'd0;
         end else if (rd_busy) begin
            ts_dout <= {1'b0, rd_data};
            rd_word <= rd_word + 6'd1;
            if (rd_last) begin
               rd_busy <= 1'b0;
               rd_ptr  <= ~rd_ptr;
            end
         end else begin
            ts_dout <= 33'd0;
         end
      end
   end

   ts_pkt_ram u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

`default_nettype wire
